// File: rtl/renkon_ctrl_issue.sv
`default_nettype none
// ============================================================================
//  Module   : renkon_ctrl_issue
//  Purpose  : Stream-issue controller. Takes a one-cycle request carrying a
//             word count and a base address, walks the operand read address,
//             and frames the stream with begin / valid / end strobes for the
//             renkon control pipeline. After the last word it waits DRAIN
//             cycles for the downstream delay, then pulses ack.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LENWIDTH   width of the word count
//    ADDRWIDTH  width of the base / read address
//    DRAIN      cycles between the last strobe and ack (0..15)
//  Ports
//    clk        clock, rising edge
//    xrst       asynchronous active-low reset
//    req        start pulse, sampled only while idle
//    len        number of words, sampled with req
//    base_addr  first read address, sampled with req
//    stall      downstream hold, suppresses issue in RUN
//    busy       frame in progress (cycle after accept .. ack, inclusive)
//    ack        one-cycle completion pulse
//    mem_addr   read address of the word being issued
//    out_begin  frame start strobe
//    out_valid  word strobe
//    out_end    frame end strobe, coincident with the last out_valid
//    err        sticky protocol error
//  Build option
//    RENKON_ISSUE_ERR_EN  when defined, err flags a req while busy or a
//                         zero-length req; otherwise err is tied low.
// ============================================================================
module renkon_ctrl_issue #(
    parameter int LENWIDTH  = 12,
    parameter int ADDRWIDTH = 12,
    parameter int DRAIN     = 2
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 req,
    input  logic [LENWIDTH-1:0]  len,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic                 stall,
    output logic                 busy,
    output logic                 ack,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 out_begin,
    output logic                 out_valid,
    output logic                 out_end,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEGIN = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]           c_DRAIN_LOAD = (DRAIN > 0) ? 4'(DRAIN - 1) : 4'd0;
    localparam logic [LENWIDTH-1:0]  c_LEN_ONE    = LENWIDTH'(1);
    localparam logic [ADDRWIDTH-1:0] c_ADDR_ONE   = ADDRWIDTH'(1);

    // The state register names the phase whose outputs are visible in the
    // current cycle; every output is a register loaded on the same edge.
    state_t                 r_state,    w_state_nxt;
    logic [LENWIDTH-1:0]    r_cnt,      w_cnt_nxt;
    logic [ADDRWIDTH-1:0]   r_addr,     w_addr_nxt;
    logic [ADDRWIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [3:0]             r_drain,    w_drain_nxt;
    logic                   r_busy,     w_busy_nxt;
    logic                   r_ack,      w_ack_nxt;
    logic                   r_begin,    w_begin_nxt;
    logic                   r_valid,    w_valid_nxt;
    logic                   r_end,      w_end_nxt;
    logic                   w_issue;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_drain    <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_begin    <= 1'b0;
            r_valid    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_drain    <= w_drain_nxt;
            r_busy     <= w_busy_nxt;
            r_ack      <= w_ack_nxt;
            r_begin    <= w_begin_nxt;
            r_valid    <= w_valid_nxt;
            r_end      <= w_end_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_mem_addr_nxt = r_mem_addr;
        w_drain_nxt    = r_drain;
        w_ack_nxt      = 1'b0;
        w_begin_nxt    = 1'b0;
        w_valid_nxt    = 1'b0;
        w_end_nxt      = 1'b0;
        w_issue        = 1'b0;
        w_busy_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (len != '0) begin
                        w_state_nxt    = S_BEGIN;
                        w_cnt_nxt      = len;
                        w_addr_nxt     = base_addr;
                        w_mem_addr_nxt = base_addr;
                        w_begin_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_ack_nxt   = 1'b1;
                    end
                end
            end
            // The first word always follows begin directly; stall is ignored
            // on this edge.
            S_BEGIN: begin
                w_state_nxt = S_RUN;
                w_issue     = 1'b1;
            end
            S_RUN: begin
                if (r_end) begin
                    if (DRAIN == 0) begin
                        w_state_nxt = S_DONE;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = c_DRAIN_LOAD;
                    end
                end else if (!stall) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain == 4'd0) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_drain_nxt = r_drain - 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Present the next word; end marks the word that empties the count.
        if (w_issue) begin
            w_valid_nxt    = 1'b1;
            w_mem_addr_nxt = r_addr;
            w_addr_nxt     = r_addr + c_ADDR_ONE;
            w_cnt_nxt      = r_cnt - c_LEN_ONE;
            w_end_nxt      = (r_cnt == c_LEN_ONE);
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign mem_addr  = r_mem_addr;
    assign out_begin = r_begin;
    assign out_valid = r_valid;
    assign out_end   = r_end;

`ifdef RENKON_ISSUE_ERR_EN
    logic r_err;

    // busy is high through the ack cycle, so a req coincident with ack is
    // also flagged.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_err <= 1'b0;
        end else if (req && (r_busy || (len == '0))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
